// File: rtl/if_row_tag_buffer.sv
// Row-tagging FWFT FIFO feeding the PE IF read path: each accepted word is tagged with
// start/end-of-row flags derived from row_len. Define IF_ROW_TAG_BUF_ERR_EN for the sticky underrun flag.
module if_row_tag_buffer #(
    parameter int DATA_WIDTH    = 16,
    parameter int DEPTH         = 16,
    parameter int ADDR_LEN      = 4,
    parameter int ROW_LEN_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_ld,
    input  logic [ROW_LEN_WIDTH-1:0] row_len,
    input  logic                     in_valid,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     in_ready,
    input  logic                     buf_read,
    output logic [DATA_WIDTH+1:0]    buf_dout,
    output logic                     buf_empty,
    output logic                     buf_full,
    output logic [ADDR_LEN:0]        count,
    output logic                     row_done,
    output logic                     err_underrun
);
    localparam logic [ADDR_LEN:0] FULL_CNT = DEPTH[ADDR_LEN:0];

    typedef enum logic {IDLE, RUN} state_t;

    state_t                   state;
    logic [DATA_WIDTH+1:0]    mem [DEPTH];
    logic [ADDR_LEN-1:0]      wr_ptr, rd_ptr;
    logic [ROW_LEN_WIDTH-1:0] col, row_len_q;
    logic                     wr_en, rd_en, cfg_ok, sof, eof;

    assign buf_empty = (count == '0);
    assign buf_full  = (count == FULL_CNT);
    assign in_ready  = (state == RUN) && !buf_full;
    assign wr_en     = in_valid && in_ready;
    assign rd_en     = buf_read && !buf_empty;
    assign sof       = (col == '0);
    assign eof       = (col == row_len_q - 1'b1);
    // New row length is only accepted on a row boundary so a row is never split.
    assign cfg_ok    = cfg_ld && (row_len != '0) && ((state == IDLE) || sof);
    assign buf_dout  = buf_empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            row_len_q <= '0;
            col       <= '0;
            row_done  <= 1'b0;
        end else begin
            row_done <= wr_en && eof;
            if (cfg_ok) begin
                state     <= RUN;
                row_len_q <= row_len;
            end
            if (wr_en)
                col <= eof ? '0 : col + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= {sof, eof, in_data};
    end

`ifdef IF_ROW_TAG_BUF_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_underrun <= 1'b0;
        else if (buf_read && buf_empty)
            err_underrun <= 1'b1;
        else if (cfg_ok)
            err_underrun <= 1'b0;
    end
`else
    assign err_underrun = 1'b0;
`endif

endmodule

// File: doc/if_row_tag_buffer.md
Name: if_row_tag_buffer

Overview:
- Upstream feeder of the PE datapath's IF read path.
- Accepts raw input-feature words from the global/NoC side using a valid/ready handshake.
- Tags each word with start-of-row and end-of-row flags, derived from a configured row length.
- Stores tagged words in a first-word-fall-through FIFO. The PE's IF reader drains it using a read strobe and an empty flag.

Parameters:
- DATA_WIDTH, 16, width of one IF word; equals the PE's IF scratch width.
- DEPTH, 16, FIFO entries; must be a power of 2.
- ADDR_LEN, 4, log2(DEPTH).
- ROW_LEN_WIDTH, 8, width of the row-length configuration.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_ld  in  1  loads row_len; honoured only under the conditions in Behaviour.
- row_len  in  ROW_LEN_WIDTH  number of IF words per row.
- in_valid  in  1  producer has a word.
- in_data  in  DATA_WIDTH  producer word.
- in_ready  out  1  buffer accepts in_data this cycle.
- buf_read  in  1  consumer pops the head entry.
- buf_dout  out  DATA_WIDTH+2  head entry: [DATA_WIDTH+1]=start flag, [DATA_WIDTH]=end flag, [DATA_WIDTH-1:0]=data.
- buf_empty  out  1  FIFO holds no entries.
- buf_full  out  1  FIFO holds DEPTH entries.
- count  out  ADDR_LEN+1  current occupancy, 0..DEPTH.
- row_done  out  1  one-cycle pulse when an end-of-row word is written.
- err_underrun  out  1  sticky error flag; see Optional Feature.

Behaviour:
- Reset (async assert; release synchronous to clk):
  - state=IDLE; wr_ptr=rd_ptr=0; count=0; col=0; row_len_q=0.
  - in_ready=0, buf_empty=1, buf_full=0, buf_dout=0, row_done=0, err_underrun=0.
  - FIFO contents are don't-care.
- FSM, 2 states:
  - IDLE: in_ready=0. Goes to RUN on cfg_ld=1 with row_len!=0; row_len_q<=row_len. cfg_ld with row_len=0 is ignored; state stays IDLE.
  - RUN: in_ready = !buf_full. cfg_ld is honoured only when col==0 (row boundary) and row_len!=0; it updates row_len_q, takes effect on the next accepted word, and state stays RUN. cfg_ld with col!=0 is ignored. No path from RUN back to IDLE except rst.
- Write, when in_valid && in_ready:
  - Entry is {col==0, col==row_len_q-1, in_data}.
  - col wraps to 0 after row_len_q-1; otherwise col increments.
  - row_done=1 in the cycle after an end-flag write (registered pulse).
  - row_len_q=1: both flags set on every word.
- Full boundary: in_ready=0 whenever buf_full=1, even if buf_read=1 in the same cycle. No write-through when full.
- Read:
  - FWFT: buf_dout combinationally shows the entry at rd_ptr when !buf_empty; buf_dout=0 when empty.
  - buf_read && !buf_empty advances rd_ptr at the edge.
  - buf_read when empty is ignored: no pointer or count change.
- Simultaneous write and read with 0<count<DEPTH: both pointers advance; count unchanged.
- Simultaneous write and read at count==0: the write lands and the read is ignored, so count goes 0->1. The new word is visible on buf_dout the cycle after the write (no same-cycle bypass).
- Pointers are ADDR_LEN bits and wrap modulo DEPTH. count is an explicit counter: +1 on write only, -1 on read only.
- buf_empty = (count==0); buf_full = (count==DEPTH); both derived combinationally from the registered count.
- Latency: word accepted at edge N is on buf_dout after edge N if the FIFO was empty, or once preceding entries are popped.
- Reset mid-row: col returns to 0 and state to IDLE. The partial row is lost, and the producer must restart from the row start after reconfiguring.

Optional Feature:
- Macro: IF_ROW_TAG_BUF_ERR_EN.
- With the macro: err_underrun is set at the edge where buf_read=1 && buf_empty=1. It stays set until rst, or until a cfg_ld that is honoured.
- Without the macro: err_underrun is tied 0 and no error logic is synthesised. All other behaviour is identical.

Test Plan:
- Reset, then cfg_ld with row_len=3. Push words 0xA,0xB,0xC,0xD with buf_read=0 -> entries stored as 0xA start=1 end=0; 0xB 0/0; 0xC 0/1 with row_done pulse one cycle after the 0xC write; 0xD 1/0. count=4.
- Reset, then cfg_ld with row_len=1, push 0x5 -> buf_dout={1,1,0x0005}.
- DEPTH=16: push 16 words with continuous in_valid -> buf_full=1, in_ready=0, count=16. Hold buf_read=1 and in_valid=1 for one cycle -> count=15, no write. Next cycle: write and read both happen, count stays 15.
- Empty FIFO: buf_read=1 -> count stays 0, buf_dout=0. err_underrun=1 with the macro, 0 without. Honoured cfg_ld clears it.
- Wrap-around: push/pop 40 words with random buf_read -> data order preserved; flags follow the col sequence for row_len=5 across pointer wraps.
- Config gating: cfg_ld row_len=4 at col=2 -> ignored; the row completes at 4 words. cfg_ld row_len=2 at col=0 -> the next row ends after 2 words. Assert rst after 3 words -> in_ready=0, count=0, buf_empty=1 immediately (async).
